// File: rtl/vga_console_writer_if.sv
// rtl/vga_console_writer_if.sv - byte stream and character-memory port bundle for vga_console_writer
// Signals:
//   in_valid, in_data[7:0], in_ready : byte stream into the writer (valid/ready)
//   char_we, char_addr[11:0]         : character memory write strobe and address {row[4:0], col[6:0]}
//   char_value[31:0]                 : character memory write data
//   char_read[31:0]                  : character memory read data
// Modports: slave = the writer, master = byte source plus character memory.
interface vga_console_writer_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        char_we;
    logic [11:0] char_addr;
    logic [31:0] char_value;
    logic [31:0] char_read;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  char_we,
        input  char_addr,
        input  char_value,
        output char_read
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output char_we,
        output char_addr,
        output char_value,
        input  char_read
    );
endinterface

// File: rtl/vga_console_writer.sv
// rtl/vga_console_writer.sv - terminal-style character writer feeding a VGA character memory
// Ports:
//   clk        : clock, all logic on posedge
//   rst        : synchronous active-high reset
//   bus        : vga_console_writer_if.slave (byte stream in, character memory port out)
//   cursor_col : current cursor column
//   cursor_row : current cursor row
//   busy       : high whenever the writer is not idle
module vga_console_writer #(
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst,
    vga_console_writer_if.slave bus,
    output logic [6:0]          cursor_col,
    output logic [4:0]          cursor_row,
    output logic                busy
);
    localparam logic [6:0] COL_MAX = 7'(COLS - 1);
    localparam logic [4:0] ROW_MAX = 5'(ROWS - 1);
    localparam logic [4:0] ROW_PEN = 5'(ROWS - 2);
    localparam logic [1:0] LAT_M1  = 2'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        PUT,
        CLEAR,
        SCR_RD,
        SCR_WAIT,
        SCR_WR,
        SCR_CLR
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  col_q, col_d;
    logic [4:0]  row_q, row_d;
    logic [4:0]  r_q, r_d;          // clear/scroll row counter
    logic [6:0]  c_q, c_d;          // clear/scroll column counter
    logic [1:0]  wait_q, wait_d;    // read-latency wait counter
    logic [6:0]  ch_q, ch_d;        // character pending for PUT
    logic        adv_q, adv_d;      // PUT advances the cursor (cleared for backspace)
    logic [31:0] value_q;           // last written word, held on char_value between writes

    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        newline;
    logic [4:0]  rd_row;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            r_q     <= '0;
            c_q     <= '0;
            wait_q  <= '0;
            ch_q    <= '0;
            adv_q   <= 1'b0;
            value_q <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            r_q     <= r_d;
            c_q     <= c_d;
            wait_q  <= wait_d;
            ch_q    <= ch_d;
            adv_q   <= adv_d;
            if (we) begin
                value_q <= wdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        r_d     = r_q;
        c_d     = c_q;
        wait_d  = wait_q;
        ch_d    = ch_q;
        adv_d   = adv_q;
        we      = 1'b0;
        addr    = '0;
        wdata   = value_q;
        newline = 1'b0;
        rd_row  = r_q + 5'd1;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.in_data >= 8'h20 && bus.in_data <= 8'h7E) begin
                        ch_d    = bus.in_data[6:0];
                        adv_d   = 1'b1;
                        state_d = PUT;
                    end else begin
                        case (bus.in_data)
                            8'h0A: newline = 1'b1;
                            8'h0D: col_d = '0;
                            8'h08: begin
                                if (col_q != '0) begin
                                    col_d   = col_q - 7'd1;
                                    ch_d    = 7'h20;
                                    adv_d   = 1'b0;
                                    state_d = PUT;
                                end
                            end
                            8'h0C: begin
                                r_d     = '0;
                                c_d     = '0;
                                state_d = CLEAR;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            PUT: begin
                we      = 1'b1;
                addr    = {row_q, col_q};
                wdata   = {25'd0, ch_q};
                state_d = IDLE;
                if (adv_q) begin
                    if (col_q == COL_MAX) begin
                        newline = 1'b1;
                    end else begin
                        col_d = col_q + 7'd1;
                    end
                end
            end
            CLEAR: begin
                we    = 1'b1;
                addr  = {r_q, c_q};
                wdata = 32'h0000_0020;
                if (c_q == COL_MAX) begin
                    c_d = '0;
                    if (r_q == ROW_MAX) begin
                        state_d = IDLE;
                        col_d   = '0;
                        row_d   = '0;
                    end else begin
                        r_d = r_q + 5'd1;
                    end
                end else begin
                    c_d = c_q + 7'd1;
                end
            end
            SCR_RD: begin
                addr   = {rd_row, c_q};
                wait_d = 2'd1;
                if (READ_LATENCY <= 1) begin
                    state_d = SCR_WR;
                end else begin
                    state_d = SCR_WAIT;
                end
            end
            SCR_WAIT: begin
                // Address stays on the source cell until read data arrives.
                addr = {rd_row, c_q};
                if (wait_q == LAT_M1) begin
                    state_d = SCR_WR;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            SCR_WR: begin
                // Copy the whole word so per-character colour survives the scroll.
                we    = 1'b1;
                addr  = {r_q, c_q};
                wdata = bus.char_read;
                if (c_q == COL_MAX) begin
                    c_d = '0;
                    if (r_q == ROW_PEN) begin
                        state_d = SCR_CLR;
                    end else begin
                        r_d     = r_q + 5'd1;
                        state_d = SCR_RD;
                    end
                end else begin
                    c_d     = c_q + 7'd1;
                    state_d = SCR_RD;
                end
            end
            SCR_CLR: begin
                we    = 1'b1;
                addr  = {ROW_MAX, c_q};
                wdata = 32'h0000_0020;
                if (c_q == COL_MAX) begin
                    c_d     = '0;
                    state_d = IDLE;
                end else begin
                    c_d = c_q + 7'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Newline shared by LF and end-of-line wrap; the bottom row scrolls instead of moving.
        if (newline) begin
            col_d = '0;
            if (row_q == ROW_MAX) begin
                r_d     = '0;
                c_d     = '0;
                state_d = SCR_RD;
            end else begin
                row_d   = row_q + 5'd1;
                state_d = IDLE;
            end
        end
    end

    assign bus.in_ready   = (state_q == IDLE) && !rst;
    assign bus.char_we    = we && !rst;
    assign bus.char_addr  = rst ? 12'd0 : addr;
    assign bus.char_value = rst ? 32'd0 : wdata;
    assign busy           = (state_q != IDLE) && !rst;
    assign cursor_col     = col_q;
    assign cursor_row     = row_q;
endmodule

// File: tb/tb_vga_console_writer.sv
// tb/tb_vga_console_writer.sv - self-checking bench for vga_console_writer
module tb_vga_console_writer;
    localparam int COLS = 80;
    localparam int ROWS = 30;

    logic       clk;
    logic       rst;
    logic [6:0] cc0, cc1;
    logic [4:0] cr0, cr1;
    logic       busy0, busy1;

    vga_console_writer_if if0 ();
    vga_console_writer_if if1 ();

    vga_console_writer #(.COLS(COLS), .ROWS(ROWS), .READ_LATENCY(1)) dut0 (
        .clk(clk), .rst(rst), .bus(if0), .cursor_col(cc0), .cursor_row(cr0), .busy(busy0));
    vga_console_writer #(.COLS(COLS), .ROWS(ROWS), .READ_LATENCY(2)) dut1 (
        .clk(clk), .rst(rst), .bus(if1), .cursor_col(cc1), .cursor_row(cr1), .busy(busy1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem0 [4096];
    logic [31:0] mem1 [4096];
    logic [31:0] rp0, rp1a, rp1b;
    logic        fill0, fill1;
    logic [31:0] model_mem [4096];
    int          mcol, mrow;
    int          sel;
    int          n_checks, n_pass, timeouts;
    int          wr_cnt0, bad0, nonsp0;
    logic [11:0] last_addr0;
    logic [31:0] last_val0;
    int          first_bad;

    function automatic logic [31:0] pattern(int a);
        return 32'h00F0_0000 | 32'(a / 128);
    endfunction

    // Character memories: synchronous read with 1 or 2 cycle latency.
    always @(posedge clk) begin
        if (if0.char_we) mem0[if0.char_addr] <= if0.char_value;
        else if (fill0) for (int a = 0; a < 4096; a++) mem0[a] <= pattern(a);
        rp0 <= mem0[if0.char_addr];
    end
    always @(posedge clk) begin
        if (if1.char_we) mem1[if1.char_addr] <= if1.char_value;
        else if (fill1) for (int a = 0; a < 4096; a++) mem1[a] <= pattern(a);
        rp1a <= mem1[if1.char_addr];
        rp1b <= rp1a;
    end
    assign if0.char_read = rp0;
    assign if1.char_read = rp1b;

    always @(negedge clk) begin
        if (if0.char_we) begin
            wr_cnt0++;
            last_addr0 = if0.char_addr;
            last_val0  = if0.char_value;
            if (int'(if0.char_addr[6:0]) >= COLS) bad0++;
            if (if0.char_value !== 32'h20) nonsp0++;
        end
    end

    function automatic logic cur_ready();
        return (sel == 0) ? if0.in_ready : if1.in_ready;
    endfunction
    function automatic logic cur_busy();
        return (sel == 0) ? busy0 : busy1;
    endfunction

    function automatic int mem_mismatch(int s);
        int n = 0;
        first_bad = -1;
        for (int a = 0; a < 4096; a++) begin
            if (((s == 0) ? mem0[a] : mem1[a]) !== model_mem[a]) begin
                if (first_bad < 0) first_bad = a;
                n++;
            end
        end
        return n;
    endfunction

    // Reference model: screen as a flat array indexed row*128+col, plus a cursor.
    task automatic model_newline(input int lat, inout int eb);
        mcol = 0;
        if (mrow < ROWS - 1) begin
            mrow++;
        end else begin
            for (int r = 0; r < ROWS - 1; r++)
                for (int c = 0; c < COLS; c++)
                    model_mem[r * 128 + c] = model_mem[(r + 1) * 128 + c];
            for (int c = 0; c < COLS; c++) model_mem[(ROWS - 1) * 128 + c] = 32'h20;
            eb += (ROWS - 1) * COLS * (lat + 1) + COLS;
        end
    endtask

    task automatic model_byte(input logic [7:0] b, input int lat, output int eb);
        eb = 0;
        if (b >= 8'h20 && b <= 8'h7E) begin
            model_mem[mrow * 128 + mcol] = {25'd0, b[6:0]};
            eb = 1;
            if (mcol < COLS - 1) mcol++;
            else model_newline(lat, eb);
        end else if (b == 8'h0A) begin
            model_newline(lat, eb);
        end else if (b == 8'h0D) begin
            mcol = 0;
        end else if (b == 8'h08) begin
            if (mcol > 0) begin
                mcol--;
                model_mem[mrow * 128 + mcol] = 32'h20;
                eb = 1;
            end
        end else if (b == 8'h0C) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) model_mem[r * 128 + c] = 32'h20;
            mcol = 0;
            mrow = 0;
            eb = ROWS * COLS;
        end
    endtask

    task automatic model_fill();
        for (int a = 0; a < 4096; a++) model_mem[a] = pattern(a);
    endtask

    task automatic send_byte(input logic [7:0] b, output int bcyc, output logic rdy_after);
        int guard;
        @(negedge clk);
        if (sel == 0) begin if0.in_valid = 1'b1; if0.in_data = b; end
        else begin if1.in_valid = 1'b1; if1.in_data = b; end
        guard = 0;
        while (!cur_ready() && guard < 100) begin @(negedge clk); guard++; end
        if (guard >= 100) timeouts++;
        @(negedge clk);
        if0.in_valid = 1'b0;
        if1.in_valid = 1'b0;
        rdy_after = cur_ready();
        bcyc = 0;
        while (cur_busy() && bcyc < 20000) begin bcyc++; @(negedge clk); end
        if (bcyc >= 20000) timeouts++;
        #1;
    endtask

    task automatic do_fill(input int s);
        @(negedge clk);
        if (s == 0) fill0 = 1'b1; else fill1 = 1'b1;
        @(negedge clk);
        fill0 = 1'b0;
        fill1 = 1'b0;
        model_fill();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        fill0 = 1'b1;
        fill1 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        fill0 = 1'b0;
        fill1 = 1'b0;
        n_checks++; if (if0.in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", if0.in_ready); else n_pass++;
        n_checks++; if (if0.char_we !== 1'b0) $display("FAIL rst_char_we: got %b want 0", if0.char_we); else n_pass++;
        n_checks++; if (if0.char_addr !== 12'd0 || if0.char_value !== 32'd0) $display("FAIL rst_addr_value: got %h/%h want 0/0", if0.char_addr, if0.char_value); else n_pass++;
        n_checks++; if (busy0 !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy0); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (cc0 !== 7'd0 || cr0 !== 5'd0) $display("FAIL rst_cursor: got (%0d,%0d) want (0,0)", cc0, cr0); else n_pass++;
        n_checks++; if (if0.in_ready !== 1'b1 || if1.in_ready !== 1'b1) $display("FAIL rst_ready_after: got %b%b want 11", if0.in_ready, if1.in_ready); else n_pass++;
        model_fill();
        mcol = 0;
        mrow = 0;
    endtask

    task automatic test_single_char();
        int w, bc, eb;
        logic ra;
        sel = 0;
        w = wr_cnt0;
        send_byte(8'h41, bc, ra);
        model_byte(8'h41, 1, eb);
        n_checks++; if (ra !== 1'b0) $display("FAIL put_ready_low: got %b want 0", ra); else n_pass++;
        n_checks++; if (wr_cnt0 - w != 1) $display("FAIL put_write_count: got %0d want 1", wr_cnt0 - w); else n_pass++;
        n_checks++; if (last_addr0 !== 12'h000 || last_val0 !== 32'h41) $display("FAIL put_write: got %h/%h want 000/00000041", last_addr0, last_val0); else n_pass++;
        n_checks++; if (int'(cc0) != mcol || int'(cr0) != mrow) $display("FAIL put_cursor: got (%0d,%0d) want (%0d,%0d)", cc0, cr0, mcol, mrow); else n_pass++;
        n_checks++; if (bc != eb) $display("FAIL put_busy: got %0d want %0d", bc, eb); else n_pass++;
        n_checks++; if (if0.in_ready !== 1'b1) $display("FAIL put_ready_back: got %b want 1", if0.in_ready); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int w, bc, eb, acc, cyc, first, last;
        logic ra;
        sel = 0;
        send_byte(8'h0D, bc, ra);
        model_byte(8'h0D, 1, eb);
        w = wr_cnt0;
        @(negedge clk);
        if0.in_valid = 1'b1;
        if0.in_data = 8'h78;
        acc = 0; cyc = 0; first = 0; last = 0;
        while (acc < COLS && cyc < 1000) begin
            if (if0.in_ready) begin
                if (acc == 0) first = cyc;
                last = cyc;
                acc++;
                model_byte(8'h78, 1, eb);
            end
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 1000) timeouts++;
        if0.in_valid = 1'b0;
        bc = 0;
        while (busy0 && bc < 100) begin bc++; @(negedge clk); end
        #1;
        n_checks++; if (last - first != 2 * (COLS - 1)) $display("FAIL b2b_throughput: got %0d cycles want %0d", last - first, 2 * (COLS - 1)); else n_pass++;
        n_checks++; if (wr_cnt0 - w != COLS) $display("FAIL b2b_write_count: got %0d want %0d", wr_cnt0 - w, COLS); else n_pass++;
        n_checks++; if (last_addr0 !== 12'h04F) $display("FAIL b2b_last_addr: got %h want 04f", last_addr0); else n_pass++;
        n_checks++; if (cc0 !== 7'd0 || cr0 !== 5'd1) $display("FAIL b2b_cursor: got (%0d,%0d) want (0,1)", cc0, cr0); else n_pass++;
        n_checks++; if (mem_mismatch(0) != 0) $display("FAIL b2b_mem: got mismatch at %0d want none", first_bad); else n_pass++;
    endtask

    task automatic test_bs_cr();
        int w, bc, eb;
        logic ra;
        sel = 0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        mcol = 0; mrow = 0;
        send_byte(8'h41, bc, ra); model_byte(8'h41, 1, eb);
        send_byte(8'h42, bc, ra); model_byte(8'h42, 1, eb);
        w = wr_cnt0;
        send_byte(8'h08, bc, ra); model_byte(8'h08, 1, eb);
        n_checks++; if (wr_cnt0 - w != 1 || last_addr0 !== 12'h001 || last_val0 !== 32'h20) $display("FAIL bs_write: got n=%0d %h/%h want n=1 001/00000020", wr_cnt0 - w, last_addr0, last_val0); else n_pass++;
        n_checks++; if (cc0 !== 7'd1 || cr0 !== 5'd0) $display("FAIL bs_cursor: got (%0d,%0d) want (1,0)", cc0, cr0); else n_pass++;
        w = wr_cnt0;
        send_byte(8'h0D, bc, ra); model_byte(8'h0D, 1, eb);
        n_checks++; if (cc0 !== 7'd0 || wr_cnt0 != w) $display("FAIL cr: got col %0d writes %0d want col 0 writes 0", cc0, wr_cnt0 - w); else n_pass++;
        send_byte(8'h08, bc, ra); model_byte(8'h08, 1, eb);
        n_checks++; if (cc0 !== 7'd0 || cr0 !== 5'd0 || wr_cnt0 != w || bc != 0) $display("FAIL bs_col0: got (%0d,%0d) writes %0d busy %0d want (0,0) 0 0", cc0, cr0, wr_cnt0 - w, bc); else n_pass++;
    endtask

    task automatic test_clear();
        int w, b, n, bc, eb;
        logic ra;
        sel = 0;
        w = wr_cnt0; b = bad0; n = nonsp0;
        send_byte(8'h0C, bc, ra);
        model_byte(8'h0C, 1, eb);
        n_checks++; if (bc != 2400) $display("FAIL clear_busy: got %0d want 2400", bc); else n_pass++;
        n_checks++; if (wr_cnt0 - w != 2400) $display("FAIL clear_writes: got %0d want 2400", wr_cnt0 - w); else n_pass++;
        n_checks++; if (bad0 != b || nonsp0 != n) $display("FAIL clear_cells: got %0d offscreen %0d nonspace want 0 0", bad0 - b, nonsp0 - n); else n_pass++;
        n_checks++; if (cc0 !== 7'd0 || cr0 !== 5'd0) $display("FAIL clear_cursor: got (%0d,%0d) want (0,0)", cc0, cr0); else n_pass++;
        n_checks++; if (mem_mismatch(0) != 0) $display("FAIL clear_mem: got mismatch at %0d want none", first_bad); else n_pass++;
    endtask

    task automatic test_scroll(input int s, input int lat, input int want_busy);
        int bc, eb;
        logic ra;
        sel = s;
        for (int i = 0; i < ROWS - 1; i++) begin send_byte(8'h0A, bc, ra); model_byte(8'h0A, lat, eb); end
        for (int i = 0; i < 5; i++) begin send_byte(8'h79, bc, ra); model_byte(8'h79, lat, eb); end
        do_fill(s);
        send_byte(8'h0A, bc, ra);
        model_byte(8'h0A, lat, eb);
        n_checks++; if (bc != want_busy) $display("FAIL scroll_busy_l%0d: got %0d want %0d", lat, bc, want_busy); else n_pass++;
        n_checks++; if (mem_mismatch(s) != 0) $display("FAIL scroll_mem_l%0d: got mismatch at %0d want none", lat, first_bad); else n_pass++;
        n_checks++; if (((s == 0) ? cc0 : cc1) !== 7'd0 || ((s == 0) ? cr0 : cr1) !== 5'd29) $display("FAIL scroll_cursor_l%0d: got (%0d,%0d) want (0,29)", lat, (s == 0) ? cc0 : cc1, (s == 0) ? cr0 : cr1); else n_pass++;
    endtask

    task automatic test_reset_mid_clear();
        int w, guard, bc, eb;
        logic ra;
        sel = 0;
        @(negedge clk);
        if0.in_valid = 1'b1;
        if0.in_data = 8'h0C;
        guard = 0;
        while (!if0.in_ready && guard < 100) begin @(negedge clk); guard++; end
        if (guard >= 100) timeouts++;
        @(negedge clk);
        if0.in_valid = 1'b0;
        repeat (100) @(negedge clk);
        n_checks++; if (busy0 !== 1'b1) $display("FAIL midclr_busy: got %b want 1", busy0); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if (if0.char_we !== 1'b0 || if0.in_ready !== 1'b0) $display("FAIL midclr_rst_cycle: got we=%b rdy=%b want 0 0", if0.char_we, if0.in_ready); else n_pass++;
        w = wr_cnt0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (if0.in_ready !== 1'b1 || busy0 !== 1'b0 || cc0 !== 7'd0 || cr0 !== 5'd0) $display("FAIL midclr_after: got rdy=%b busy=%b (%0d,%0d) want 1 0 (0,0)", if0.in_ready, busy0, cc0, cr0); else n_pass++;
        repeat (20) @(negedge clk);
        #1;
        n_checks++; if (wr_cnt0 != w) $display("FAIL midclr_no_writes: got %0d want 0", wr_cnt0 - w); else n_pass++;
        mcol = 0; mrow = 0;
        send_byte(8'h51, bc, ra);
        model_byte(8'h51, 1, eb);
        n_checks++; if (wr_cnt0 - w != 1 || last_addr0 !== 12'h000 || last_val0 !== 32'h51) $display("FAIL midclr_next: got n=%0d %h/%h want n=1 000/00000051", wr_cnt0 - w, last_addr0, last_val0); else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] others [7];
        logic [7:0] b;
        int bc, eb, k;
        logic ra;
        others[0] = 8'h00; others[1] = 8'h07; others[2] = 8'h09; others[3] = 8'h1B;
        others[4] = 8'h7F; others[5] = 8'h80; others[6] = 8'hFF;
        sel = 0;
        do_fill(0);
        for (int i = 0; i < 27; i++) begin send_byte(8'h0A, bc, ra); model_byte(8'h0A, 1, eb); end
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 15);
            if (k <= 8) b = 8'($urandom_range(32, 126));
            else if (k <= 10) b = 8'h0A;
            else if (k == 11) b = 8'h0D;
            else if (k == 12) b = 8'h08;
            else b = others[$urandom_range(0, 6)];
            send_byte(b, bc, ra);
            model_byte(b, 1, eb);
            n_checks++; if (bc != eb) $display("FAIL rand_busy[%0d] byte %h: got %0d want %0d", i, b, bc, eb); else n_pass++;
            n_checks++; if (int'(cc0) != mcol || int'(cr0) != mrow) $display("FAIL rand_cursor[%0d] byte %h: got (%0d,%0d) want (%0d,%0d)", i, b, cc0, cr0, mcol, mrow); else n_pass++;
        end
        n_checks++; if (mem_mismatch(0) != 0) $display("FAIL rand_mem: got mismatch at %0d want none", first_bad); else n_pass++;
    endtask

    initial begin
        n_checks = 0; n_pass = 0; timeouts = 0;
        wr_cnt0 = 0; bad0 = 0; nonsp0 = 0;
        sel = 0;
        fill0 = 1'b0; fill1 = 1'b0;
        if0.in_valid = 1'b0; if0.in_data = 8'h00;
        if1.in_valid = 1'b0; if1.in_data = 8'h00;
        rst = 1'b1;
        test_reset();
        test_single_char();
        test_back_to_back();
        test_bs_cr();
        test_clear();
        test_scroll(0, 1, 4720);
        mcol = 0; mrow = 0;
        test_scroll(1, 2, 7040);
        test_reset_mid_clear();
        test_random();
        n_checks++; if (timeouts != 0) $display("FAIL timeouts: got %0d want 0", timeouts); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
